// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone arbiter.
// The grant is round-robin and is held for as long as the granted master keeps
// cyc high. A watchdog ends slave accesses that stall without an ack, so a
// dead slave cannot hang the command path.
module wishbone_arbiter #(
   parameter int          TIMEOUT      = 256,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
   input  logic        clk,
   input  logic        rst,
   // master 0
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic        m0_str_i,
   input  logic        m0_cyc_i,
   input  logic        m0_we_i,
   input  logic        m0_msk_i,
   input  logic        m0_sel_i,
   output logic        m0_ack_o,
   // master 1
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic        m1_str_i,
   input  logic        m1_cyc_i,
   input  logic        m1_we_i,
   input  logic        m1_msk_i,
   input  logic        m1_sel_i,
   output logic        m1_ack_o,
   // slave
   output logic [31:0] s_addr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   output logic        s_str_o,
   output logic        s_cyc_o,
   output logic        s_we_o,
   output logic        s_msk_o,
   output logic        s_sel_o,
   input  logic        s_ack_i,
   // status
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   // The counter only ever has to hold 0..TIMEOUT.
   localparam int             CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam bit             WD_EN       = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t           state, state_next;
   logic             last_grant;   // 0 = m0 was granted last, 1 = m1
   logic [CNT_W-1:0] wd_cnt;
   logic             sel_cyc, sel_str, stall, fire;

   // Next-state: round-robin on a tie from IDLE, no preemption, direct handoff.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_next = last_grant ? GRANT0 : GRANT1;
            else if (m0_cyc_i)        state_next = GRANT0;
            else if (m1_cyc_i)        state_next = GRANT1;
         end
         GRANT0:  if (!m0_cyc_i) state_next = m1_cyc_i ? GRANT1 : IDLE;
         GRANT1:  if (!m1_cyc_i) state_next = m0_cyc_i ? GRANT0 : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; last_grant follows each entry into a grant state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
         state      <= IDLE;
         last_grant <= 1'b1;   // m0 wins the first tie after reset
      end else begin
         state <= state_next;
         if (state_next == GRANT0)      last_grant <= 1'b0;
         else if (state_next == GRANT1) last_grant <= 1'b1;
      end
   end

   // Watchdog: consecutive stalled cycles of the current grant, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (!WD_EN || state_next != state || !stall || fire) begin
         wd_cnt <= '0;
      end else if (wd_cnt != TIMEOUT_CNT) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   // A stall is judged on the master's own strobe, before the watchdog gates it.
   assign stall     = sel_cyc && sel_str && !s_ack_i;
   assign fire      = WD_EN && stall && (wd_cnt == TIMEOUT_CNT);
   assign timeout_o = fire;

   // Route the granted master onto the slave side; everything reads 0 in IDLE.
   always_comb begin
      sel_cyc  = 1'b0;
      sel_str  = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_msk_o  = 1'b0;
      s_sel_o  = 1'b0;
      grant_o  = 2'b00;
      case (state)
         GRANT0: begin
            sel_cyc  = m0_cyc_i;
            sel_str  = m0_str_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_msk_o  = m0_msk_i;
            s_sel_o  = m0_sel_i;
            grant_o  = 2'b01;
         end
         GRANT1: begin
            sel_cyc  = m1_cyc_i;
            sel_str  = m1_str_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_msk_o  = m1_msk_i;
            s_sel_o  = m1_sel_i;
            grant_o  = 2'b10;
         end
         default: ;
      endcase
      s_cyc_o = sel_cyc;
      s_str_o = sel_str && !fire;
   end

   // Return path: ack only while the owner still holds cyc, so an abandoned
   // access never sees a late slave ack; the watchdog substitutes its own.
   always_comb begin
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      case (state)
         GRANT0: begin
            m0_ack_o = m0_cyc_i && (s_ack_i || fire);
            m0_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
         end
         GRANT1: begin
            m1_ack_o = m1_cyc_i && (s_ack_i || fire);
            m1_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter. It lets the host-command wishbone_master share the slave interconnect with a second bus master, such as a DMA engine.
- Grant is round-robin and is held for the whole cycle, for as long as the granted master keeps cyc high.
- A watchdog terminates slave accesses that stall and never ack, so the command path cannot hang.

Parameters:
TIMEOUT, 256, cycles with str high and no ack before the watchdog fires; 0 disables the watchdog.
TIMEOUT_DATA, 32'hDEADDEAD, read data returned to the master on a watchdog termination.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
m0_addr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_str_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle / bus request
m0_we_i  in  1  master 0 write enable
m0_msk_i  in  1  master 0 mask
m0_sel_i  in  1  master 0 select
m0_ack_o  out  1  master 0 acknowledge
m1_* (addr_i, dat_i, dat_o, str_i, cyc_i, we_i, msk_i, sel_i, ack_o)  same widths and meaning, master 1
s_addr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_str_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_we_o  out  1  slave write enable
s_msk_o  out  1  slave mask
s_sel_o  out  1  slave select
s_ack_i  in  1  slave acknowledge
grant_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = none
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset:
  - rst is asynchronous and active-high; all state clears immediately on assertion.
  - On reset, state goes to IDLE, grant_o=00, last_grant=m1 (so m0 wins the first tie), watchdog count=0, timeout_o=0.
  - Slave outputs and both master ack/dat outputs read 0 while in reset.
- States:
  - IDLE: no grant. All s_* outputs = 0. m*_ack_o = 0, m*_dat_o = 0.
  - GRANT0 / GRANT1: granted master's signals pass combinationally to s_*. s_ack_i and s_dat_i pass to that master. The other master sees ack_o=0, dat_o=0.
- Transitions (registered, evaluated each rising edge):
  - IDLE, one cyc high -> grant that master.
  - IDLE, both cyc high -> grant the master that is not last_grant.
  - GRANTx, m_x cyc stays high -> remain in GRANTx. No preemption.
  - GRANTx, m_x cyc low and other cyc high -> go directly to GRANTother (handoff, no IDLE bubble).
  - GRANTx, m_x cyc low and other cyc low -> IDLE.
  - last_grant updates on every entry into GRANTx.
- Latency:
  - cyc rising in cycle N from IDLE -> grant_o and s_cyc_o valid in cycle N+1.
  - Release: s_cyc_o drops in the same cycle the granted master drops cyc (combinational pass-through). Grant changes at the next edge.
- Watchdog:
  - Counter counts consecutive cycles with a grant active, s_str_o=1 and s_ack_i=0.
  - Counter clears on s_ack_i=1, on str low, and on any grant change.
  - When count reaches TIMEOUT, for exactly one cycle:
    - granted m_ack_o=1 and m_dat_o=TIMEOUT_DATA;
    - s_str_o is forced to 0;
    - timeout_o=1;
    - the counter then clears.
  - If s_ack_i arrives in the same cycle as expiry, the real ack wins and the watchdog does not fire.
  - Counter is wide enough for TIMEOUT and saturates; it never wraps.
- Edge cases:
  - Reset mid-transfer: grant drops asynchronously and s_cyc_o/s_str_o go low immediately. A pending ack is discarded.
  - A master dropping cyc while str is high abandons the access; any late s_ack_i is not forwarded to anyone.

Test Plan:
- Single request: m0 cyc/str high with addr 0x00000010, write, data 0x12345678; slave acks after 3 cycles -> grant_o=01 one cycle after cyc; s_addr_o=0x10, s_dat_o=0x12345678; m0_ack_o pulses with s_ack_i; m1_ack_o stays 0.
- Simultaneous request from reset: m0 and m1 cyc rise together, each runs 2 transfers and releases -> grant order m0 then m1, with handoff and no idle cycle between. Repeat the tie -> m0 wins again, because last_grant was m1.
- Hold: m1 granted, m0 requests mid-cycle, m1 completes 4 transfers before dropping cyc -> grant_o stays 10 throughout, then switches to 01 on the cycle after m1 cyc falls.
- Watchdog: TIMEOUT=8, slave never acks m0 read -> after 8 stalled cycles: m0_ack_o=1, m0_dat_o=0xDEADDEAD, timeout_o=1, s_str_o=0, all for one cycle. An ack arriving exactly at expiry -> timeout_o stays 0 and the real data is returned.
- Async reset: assert rst mid-transfer in GRANT1 -> grant_o=00 and s_cyc_o=0 in the same cycle without waiting for an edge. After release, an m0 request is granted first.
